// File: rtl/game_pkg.sv
// Shared definitions for the memory-game datapath (playback and input_checker).
// Holds the checker FSM encoding, level geometry and small note helpers.
package game_pkg;

    localparam int NOTE_W    = 4;
    localparam int MAX_NOTES = 4;
    localparam int LEVEL_W   = 16;
    localparam int IDX_W     = 3;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        WAIT_PRESS,
        WAIT_RELEASE,
        PASS,
        FAIL
    } state_t;

    // Index 0 is the most significant nibble, i.e. the first note played.
    function automatic logic [NOTE_W-1:0] note_at(input logic [LEVEL_W-1:0] data,
                                                  input logic [IDX_W-1:0]   idx);
        case (idx)
            3'd0:    note_at = data[15:12];
            3'd1:    note_at = data[11:8];
            3'd2:    note_at = data[7:4];
            3'd3:    note_at = data[3:0];
            default: note_at = '0;
        endcase
    endfunction

    function automatic logic [IDX_W-1:0] clamp_length(input logic [3:0] len);
        clamp_length = (len > 4'(MAX_NOTES)) ? IDX_W'(MAX_NOTES) : len[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/key_edge.sv
// Key press edge detector: a press is any key going down while all keys were up
// on the previous cycle, so a key held from earlier is ignored until released.
module key_edge
    import game_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [NOTE_W-1:0] keys,
    output logic              press,
    output logic              released
);

    logic [NOTE_W-1:0] keys_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            keys_q <= '0;
        end else begin
            keys_q <= keys;
        end
    end

    assign press    = (keys != '0) && (keys_q == '0);
    assign released = (keys == '0);

endmodule

// File: rtl/input_checker.sv
// Player-response checker: latches a level, then compares each key press against
// the expected note with a per-note timeout, reporting a sticky pass or fail.
module input_checker
    import game_pkg::*;
#(
    parameter int TIMEOUT = 100,
    parameter int TW      = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [LEVEL_W-1:0] level_data,
    input  logic [3:0]         level_length,
    input  logic               load_level,
    input  logic               start_input,
    input  logic [NOTE_W-1:0]  keys,
    output logic [NOTE_W-1:0]  note_echo,
    output logic [IDX_W-1:0]   note_index,
    output logic               input_done,
    output logic               pass,
    output logic               fail
);

    localparam logic [TW-1:0] RELOAD = TW'(TIMEOUT - 1);

    state_t             state, state_n;
    logic [LEVEL_W-1:0] data_q, data_n;
    logic [IDX_W-1:0]   len_q, len_n;
    logic [IDX_W-1:0]   idx_q, idx_n;
    logic [TW-1:0]      timer_q, timer_n;
    logic [NOTE_W-1:0]  echo_q, echo_n;
    logic               pass_q, fail_q;

    logic               press;
    logic               released;
    logic [NOTE_W-1:0]  expected;
    logic [IDX_W-1:0]   idx_inc;

    key_edge u_key_edge (
        .clk      (clk),
        .reset    (reset),
        .keys     (keys),
        .press    (press),
        .released (released)
    );

    assign expected = note_at(data_q, idx_q);
    assign idx_inc  = idx_q + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            data_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            timer_q <= '0;
            echo_q  <= '0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state   <= state_n;
            data_q  <= data_n;
            len_q   <= len_n;
            idx_q   <= idx_n;
            timer_q <= timer_n;
            echo_q  <= echo_n;
            pass_q  <= (state_n == PASS);
            fail_q  <= (state_n == FAIL);
        end
    end

    // A press on the same cycle the timer expires is still judged, not timed out.
    always_comb begin
        state_n = state;
        data_n  = data_q;
        len_n   = len_q;
        idx_n   = idx_q;
        timer_n = timer_q;
        echo_n  = echo_q;

        if (load_level) begin
            data_n  = level_data;
            len_n   = clamp_length(level_length);
            idx_n   = '0;
            state_n = ARMED;
        end else begin
            case (state)
                ARMED: begin
                    if (start_input) begin
                        if (len_q == '0) begin
                            state_n = PASS;
                        end else begin
                            state_n = WAIT_PRESS;
                            timer_n = RELOAD;
                        end
                    end
                end
                WAIT_PRESS: begin
                    if (press) begin
                        echo_n = keys;
                        if (keys == expected) begin
                            idx_n   = idx_inc;
                            state_n = (idx_inc == len_q) ? PASS : WAIT_RELEASE;
                        end else begin
                            state_n = FAIL;
                        end
                    end else if (timer_q == '0) begin
                        state_n = FAIL;
                    end else begin
                        timer_n = timer_q - TW'(1);
                    end
                end
                WAIT_RELEASE: begin
                    if (released) begin
                        state_n = WAIT_PRESS;
                        timer_n = RELOAD;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign note_echo  = echo_q;
    assign note_index = idx_q;
    assign pass       = pass_q;
    assign fail       = fail_q;
    assign input_done = pass_q | fail_q;

endmodule

// File: tb/tb_input_checker.sv
// Randomized scoreboard bench for input_checker: a behavioural game model predicts
// the outputs after every clock edge and a monitor compares them against the DUT.
module tb_input_checker;

    localparam int TIMEOUT = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] level_data;
    logic [3:0]  level_length;
    logic        load_level;
    logic        start_input;
    logic [3:0]  keys;
    logic [3:0]  note_echo;
    logic [2:0]  note_index;
    logic        input_done;
    logic        pass;
    logic        fail;

    always #5 clk = ~clk;

    input_checker #(.TIMEOUT(TIMEOUT), .TW(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .level_data   (level_data),
        .level_length (level_length),
        .load_level   (load_level),
        .start_input  (start_input),
        .keys         (keys),
        .note_echo    (note_echo),
        .note_index   (note_index),
        .input_done   (input_done),
        .pass         (pass),
        .fail         (fail)
    );

    typedef struct packed {
        logic [3:0] echo;
        logic [2:0] idx;
        logic       done;
        logic       pass;
        logic       fail;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    // Behavioural game model: notes as an array, a deadline in absolute cycles.
    int     m_notes[4];
    int     m_len, m_idx, m_echo, m_prev_keys;
    bit     m_armed, m_active, m_wait_release, m_pass, m_fail;
    longint m_cycle = 0;
    longint m_deadline = 0;

    logic [15:0] cur_data = 16'h0;
    logic [3:0]  cur_len = 4'h0;

    task automatic model_step(input bit r, input bit ld, input bit st,
                              input logic [15:0] d, input logic [3:0] ln,
                              input logic [3:0] k);
        bit   is_press;
        exp_t e;
        m_cycle++;
        is_press = (k != 4'h0) && (m_prev_keys == 0);
        if (r) begin
            for (int i = 0; i < 4; i++) m_notes[i] = 0;
            m_len = 0; m_idx = 0; m_echo = 0;
            m_armed = 0; m_active = 0; m_wait_release = 0; m_pass = 0; m_fail = 0;
        end else if (ld) begin
            for (int i = 0; i < 4; i++) m_notes[i] = int'((d >> (12 - 4 * i)) & 16'hF);
            m_len = (int'(ln) > 4) ? 4 : int'(ln);
            m_idx = 0; m_pass = 0; m_fail = 0;
            m_armed = 1; m_active = 0; m_wait_release = 0;
        end else if (m_armed && st) begin
            m_armed = 0;
            if (m_len == 0) m_pass = 1;
            else begin
                m_active = 1;
                m_wait_release = 0;
                m_deadline = m_cycle + TIMEOUT;
            end
        end else if (m_active && !m_wait_release) begin
            if (is_press) begin
                m_echo = int'(k);
                if (int'(k) == m_notes[m_idx]) begin
                    m_idx++;
                    if (m_idx == m_len) begin m_pass = 1; m_active = 0; end
                    else m_wait_release = 1;
                end else begin
                    m_fail = 1; m_active = 0;
                end
            end else if (m_cycle >= m_deadline) begin
                m_fail = 1; m_active = 0;
            end
        end else if (m_active && m_wait_release && k == 4'h0) begin
            m_wait_release = 0;
            m_deadline = m_cycle + TIMEOUT;
        end
        m_prev_keys = r ? 0 : int'(k);
        e.echo = 4'(m_echo);
        e.idx  = 3'(m_idx);
        e.done = m_pass | m_fail;
        e.pass = m_pass;
        e.fail = m_fail;
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input bit r, input bit ld, input bit st,
                                 input logic [15:0] d, input logic [3:0] ln,
                                 input logic [3:0] k);
        reset = r; load_level = ld; start_input = st;
        level_data = d; level_length = ln; keys = k;
        @(posedge clk);
        model_step(r, ld, st, d, ln, k);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input bit ep, input bit ef,
                               input int eidx, input int eecho);
        checks++;
        if (pass !== ep || fail !== ef || input_done !== (ep | ef) ||
            note_index !== 3'(eidx) || note_echo !== 4'(eecho)) begin
            $display("[TB] FAIL %s: got pass=%b fail=%b done=%b idx=%0d echo=%h, expected pass=%b fail=%b done=%b idx=%0d echo=%h",
                     name, pass, fail, input_done, note_index, note_echo,
                     ep, ef, ep | ef, eidx, eecho);
        end else begin
            passes++;
        end
    endtask

    task automatic step(input logic [3:0] k);
        applyStimulus(0, 0, 0, cur_data, cur_len, k);
    endtask

    task automatic do_reset();
        applyStimulus(1, 0, 0, cur_data, cur_len, 4'h0);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] ln);
        cur_data = d; cur_len = ln;
        applyStimulus(0, 1, 0, d, ln, 4'h0);
    endtask

    task automatic do_start();
        applyStimulus(0, 0, 1, cur_data, cur_len, 4'h0);
    endtask

    task automatic press_key(input logic [3:0] k);
        step(k);
        step(4'h0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({note_echo, note_index, input_done, pass, fail} !== e) begin
                    $display("[TB] FAIL cycle_outputs @%0t: got echo=%h idx=%0d done=%b pass=%b fail=%b, expected echo=%h idx=%0d done=%b pass=%b fail=%b",
                             $time, note_echo, note_index, input_done, pass, fail,
                             e.echo, e.idx, e.done, e.pass, e.fail);
                end else begin
                    passes++;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected to finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; load_level = 1'b0; start_input = 1'b0;
        level_data = '0; level_length = '0; keys = '0;
        @(negedge clk);

        do_reset();
        checkOutput("reset_state", 0, 0, 0, 0);

        do_load(16'h1248, 4'd4);
        do_start();
        press_key(4'h1); press_key(4'h2); press_key(4'h4);
        checkOutput("happy_three_notes", 0, 0, 3, 4);
        step(4'h8);
        checkOutput("happy_pass", 1, 0, 4, 8);
        step(4'h0); step(4'h1);
        checkOutput("pass_sticky", 1, 0, 4, 8);

        do_reset();
        do_load(16'h1248, 4'd4);
        do_start();
        press_key(4'h1);
        step(4'h4);
        checkOutput("wrong_note", 0, 1, 1, 4);

        do_reset();
        do_load(16'h1248, 4'd4);
        do_start();
        repeat (9) step(4'h0);
        checkOutput("timeout_minus_one", 0, 0, 0, 0);
        step(4'h0);
        checkOutput("timeout_fail", 0, 1, 0, 0);

        do_reset();
        do_load(16'h1248, 4'd4);
        do_start();
        repeat (9) step(4'h0);
        step(4'h1);
        checkOutput("press_at_deadline", 0, 0, 1, 1);

        do_reset();
        cur_data = 16'h1248; cur_len = 4'd4;
        applyStimulus(0, 1, 0, cur_data, cur_len, 4'h1);
        applyStimulus(0, 0, 1, cur_data, cur_len, 4'h1);
        repeat (3) step(4'h1);
        checkOutput("held_key_ignored", 0, 0, 0, 0);
        step(4'h0);
        step(4'h1);
        checkOutput("held_then_press", 0, 0, 1, 1);

        do_reset();
        do_load(16'h1248, 4'd0);
        do_start();
        checkOutput("length_zero_pass", 1, 0, 0, 0);

        do_reset();
        do_load(16'h1248, 4'd9);
        do_start();
        press_key(4'h1); press_key(4'h2); press_key(4'h4);
        step(4'h8);
        checkOutput("length_nine_as_four", 1, 0, 4, 8);

        do_reset();
        do_load(16'h8100, 4'd2);
        do_start();
        press_key(4'h8);
        step(4'h1);
        checkOutput("length_two_pass", 1, 0, 2, 1);

        do_reset();
        do_load(16'h1248, 4'd4);
        do_start();
        press_key(4'h1); press_key(4'h2);
        do_load(16'h1248, 4'd4);
        checkOutput("reload_mid_game", 0, 0, 0, 2);
        do_start();
        press_key(4'h1);
        do_reset();
        checkOutput("reset_mid_game", 0, 0, 0, 0);

        for (int n = 0; n < 3000; n++) begin
            bit          r, ld, st;
            logic [15:0] d;
            logic [3:0]  ln, k;
            int          p;
            r  = ($urandom_range(0, 299) == 0);
            ld = ($urandom_range(0, 59) == 0);
            st = ($urandom_range(0, 5) == 0);
            d  = 16'($urandom);
            p  = $urandom_range(0, 3);
            ln = (p == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
            p  = $urandom_range(0, 9);
            if (p < 5)      k = 4'h0;
            else if (p < 8) k = 4'(m_notes[(m_idx < 4) ? m_idx : 0]);
            else            k = 4'($urandom);
            applyStimulus(r, ld, st, d, ln, k);
        end

        step(4'h0);
        step(4'h0);
        checks++;
        if (exp_q.size() != 0) begin
            $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
        end else begin
            passes++;
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
